// File: rtl/pac_sprite_if.sv
// Raster/bitmap bus between the VGA timing side, the Pacman bitmap ROM and the sprite scanner.
// The scanner uses the slave view; the timing generator and the bitmap together form the master side.
interface pac_sprite_if #(
   parameter int COORD_W = 10
);
   logic               pix_en;
   logic               frame_start;
   logic [COORD_W-1:0] hcount;
   logic [COORD_W-1:0] vcount;
   logic [COORD_W-1:0] pac_x;
   logic [COORD_W-1:0] pac_y;
   logic [3:0]         dir_req;
   logic               sprite_pixel;
   logic [4:0]         sprite_x;
   logic [4:0]         sprite_y;
   logic [3:0]         sprite_dir;
   logic               pac_on;
   logic               mouth_open;

   modport master (
      output pix_en, frame_start, hcount, vcount, pac_x, pac_y, dir_req, sprite_pixel,
      input  sprite_x, sprite_y, sprite_dir, pac_on, mouth_open
   );

   modport slave (
      input  pix_en, frame_start, hcount, vcount, pac_x, pac_y, dir_req, sprite_pixel,
      output sprite_x, sprite_y, sprite_dir, pac_on, mouth_open
   );
endinterface

// File: rtl/pac_sprite_scan.sv
// Pacman sprite scanner: raster position -> local bitmap coordinates, then the bitmap pixel is
// registered as pac_on. Position, facing and mouth phase are latched once per frame.
module pac_sprite_scan #(
   parameter int SIZE        = 24,
   parameter int ANIM_FRAMES = 8,
   parameter int COORD_W     = 10
) (
   input  logic         clk,
   input  logic         rst,
   pac_sprite_if.slave  bus
);
   localparam int                CNT_W    = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
   localparam logic [COORD_W:0]  SIZE_C   = (COORD_W+1)'(SIZE);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ANIM_FRAMES - 1);

   logic [COORD_W-1:0] pos_x, pos_y;
   logic [3:0]         dir_lat;
   logic [CNT_W-1:0]   anim_cnt;
   logic               mouth;
   logic               valid1;
   logic               in_box;
   logic               dir_ok;
   logic [COORD_W:0]   dx, dy;

   // One extra bit on the differences keeps a sprite near the right/bottom edge from aliasing onto column/row 0.
   always_comb begin
      dx     = {1'b0, bus.hcount} - {1'b0, pos_x};
      dy     = {1'b0, bus.vcount} - {1'b0, pos_y};
      in_box = (bus.hcount >= pos_x) && (dx < SIZE_C) &&
               (bus.vcount >= pos_y) && (dy < SIZE_C);
      dir_ok = (bus.dir_req != 4'b0000) && ((bus.dir_req & (bus.dir_req - 4'd1)) == 4'b0000);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos_x    <= '0;
         pos_y    <= '0;
         dir_lat  <= 4'b0000;
         anim_cnt <= '0;
         mouth    <= 1'b0;
      end else if (bus.frame_start) begin
         pos_x <= bus.pac_x;
         pos_y <= bus.pac_y;
         if (dir_ok)
            dir_lat <= bus.dir_req;
         if (anim_cnt == CNT_LAST) begin
            anim_cnt <= '0;
            mouth    <= ~mouth;
         end else begin
            anim_cnt <= anim_cnt + 1'b1;
         end
      end
   end

   // Two-stage pixel pipeline; sprite_pixel is the combinational bitmap answer for stage-1 outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.sprite_x   <= 5'd0;
         bus.sprite_y   <= 5'd0;
         bus.sprite_dir <= 4'b0000;
         valid1         <= 1'b0;
         bus.pac_on     <= 1'b0;
      end else if (bus.pix_en) begin
         bus.sprite_x   <= in_box ? dx[4:0] : 5'd0;
         bus.sprite_y   <= in_box ? dy[4:0] : 5'd0;
         bus.sprite_dir <= mouth ? dir_lat : 4'b0000;
         valid1         <= in_box;
         bus.pac_on     <= valid1 & bus.sprite_pixel;
      end
   end

   assign bus.mouth_open = mouth;
endmodule

// File: tb/tb_pac_sprite_scan.sv
// Self-checking bench for pac_sprite_scan: directed scenarios plus randomized raster traffic
// compared against an integer-arithmetic model of the sprite window and animation.
module tb_pac_sprite_scan;
   localparam int SIZE = 24;
   localparam int ANIM = 8;
   localparam int CW   = 10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pac_sprite_if #(.COORD_W(CW)) bus();

   pac_sprite_scan #(.SIZE(SIZE), .ANIM_FRAMES(ANIM), .COORD_W(CW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   bit bmp [32][32];
   assign bus.sprite_pixel = bmp[bus.sprite_x][bus.sprite_y];

   // reference model state
   int         m_px, m_py, m_cnt;
   logic [3:0] m_dir;
   logic       m_mouth;
   bit         p_in;
   int         p_lx, p_ly;
   logic       e_on;
   logic [4:0] e_sx, e_sy;
   logic [3:0] e_dir;
   int         n_chk, n_fail;

   task automatic model_reset();
      m_px = 0; m_py = 0; m_cnt = 0; m_dir = 4'b0000; m_mouth = 1'b0;
      p_in = 1'b0; p_lx = 0; p_ly = 0;
      e_on = 1'b0; e_sx = 5'd0; e_sy = 5'd0; e_dir = 4'b0000;
   endtask

   task automatic clear_bmp(input bit val);
      for (int i = 0; i < 32; i++)
         for (int j = 0; j < 32; j++)
            bmp[i][j] = val;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      bus.pix_en = 1'b0; bus.frame_start = 1'b0;
      bus.hcount = '0; bus.vcount = '0; bus.pac_x = '0; bus.pac_y = '0; bus.dir_req = 4'b0000;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // One clock: drive at negedge, update the model at the edge, leave outputs to be sampled 1ns later.
   task automatic step(input bit pix, input bit fs, input int h, input int v);
      bit inb;
      @(negedge clk);
      bus.pix_en = pix; bus.frame_start = fs;
      bus.hcount = CW'(h); bus.vcount = CW'(v);
      @(posedge clk);
      if (pix) begin
         e_on  = p_in && bmp[p_lx][p_ly];
         inb   = (h >= m_px) && (h - m_px < SIZE) && (v >= m_py) && (v - m_py < SIZE);
         e_sx  = inb ? 5'(h - m_px) : 5'd0;
         e_sy  = inb ? 5'(v - m_py) : 5'd0;
         e_dir = m_mouth ? m_dir : 4'b0000;
         p_in  = inb; p_lx = int'(e_sx); p_ly = int'(e_sy);
      end
      if (fs) begin
         m_px = int'(bus.pac_x); m_py = int'(bus.pac_y);
         if ($countones(bus.dir_req) == 1) m_dir = bus.dir_req;
         if (m_cnt == ANIM - 1) begin m_cnt = 0; m_mouth = ~m_mouth; end
         else m_cnt++;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.pix_en = 1'b0; bus.frame_start = 1'b0;
      bus.hcount = '0; bus.vcount = '0; bus.pac_x = '0; bus.pac_y = '0; bus.dir_req = 4'b0000;
      #12;
      n_chk += 5;
      if (bus.sprite_x !== 5'd0)      begin n_fail++; $display("FAIL reset sprite_x got %0d exp 0", bus.sprite_x); end
      if (bus.sprite_y !== 5'd0)      begin n_fail++; $display("FAIL reset sprite_y got %0d exp 0", bus.sprite_y); end
      if (bus.sprite_dir !== 4'b0000) begin n_fail++; $display("FAIL reset sprite_dir got %b exp 0000", bus.sprite_dir); end
      if (bus.pac_on !== 1'b0)        begin n_fail++; $display("FAIL reset pac_on got %b exp 0", bus.pac_on); end
      if (bus.mouth_open !== 1'b0)    begin n_fail++; $display("FAIL reset mouth_open got %b exp 0", bus.mouth_open); end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_first_frame();
      clear_bmp(1'b0);
      bmp[0][0] = 1'b1;
      bus.pac_x = 10'd100; bus.pac_y = 10'd50; bus.dir_req = 4'b0010;
      step(0, 1, 0, 0);
      n_chk += 1;
      if (bus.mouth_open !== 1'b0) begin n_fail++; $display("FAIL first_frame mouth_open got %b exp 0", bus.mouth_open); end
      step(1, 0, 100, 50);
      n_chk += 3;
      if (bus.sprite_x !== 5'd0 || e_sx !== 5'd0) begin n_fail++; $display("FAIL first_frame sprite_x got %0d exp 0", bus.sprite_x); end
      if (bus.sprite_y !== 5'd0)      begin n_fail++; $display("FAIL first_frame sprite_y got %0d exp 0", bus.sprite_y); end
      if (bus.sprite_dir !== e_dir)   begin n_fail++; $display("FAIL first_frame sprite_dir got %b exp %b", bus.sprite_dir, e_dir); end
      step(1, 0, 101, 50);
      n_chk += 2;
      if (bus.pac_on !== 1'b1)        begin n_fail++; $display("FAIL first_frame pac_on got %b exp 1", bus.pac_on); end
      if (bus.sprite_x !== e_sx)      begin n_fail++; $display("FAIL first_frame sprite_x2 got %0d exp %0d", bus.sprite_x, e_sx); end
   endtask

   task automatic test_box_edge();
      bmp[23][23] = 1'b1;
      step(1, 0, 123, 73);
      n_chk += 2;
      if (bus.sprite_x !== 5'd23) begin n_fail++; $display("FAIL box_edge sprite_x got %0d exp 23", bus.sprite_x); end
      if (bus.sprite_y !== 5'd23) begin n_fail++; $display("FAIL box_edge sprite_y got %0d exp 23", bus.sprite_y); end
      step(1, 0, 124, 73);
      n_chk += 3;
      if (bus.sprite_x !== 5'd0)  begin n_fail++; $display("FAIL box_edge out sprite_x got %0d exp 0", bus.sprite_x); end
      if (bus.sprite_y !== 5'd0)  begin n_fail++; $display("FAIL box_edge out sprite_y got %0d exp 0", bus.sprite_y); end
      if (bus.pac_on !== e_on)    begin n_fail++; $display("FAIL box_edge corner pac_on got %b exp %b", bus.pac_on, e_on); end
      step(1, 0, 125, 73);
      n_chk += 1;
      if (bus.pac_on !== 1'b0)    begin n_fail++; $display("FAIL box_edge out pac_on got %b exp 0", bus.pac_on); end
   endtask

   task automatic test_anim();
      apply_reset();
      bus.dir_req = 4'b1000;
      repeat (ANIM) step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      n_chk += 2;
      if (bus.mouth_open !== 1'b1)    begin n_fail++; $display("FAIL anim open mouth got %b exp 1", bus.mouth_open); end
      if (bus.sprite_dir !== 4'b1000) begin n_fail++; $display("FAIL anim open dir got %b exp 1000", bus.sprite_dir); end
      repeat (ANIM) step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      n_chk += 2;
      if (bus.mouth_open !== 1'b0)    begin n_fail++; $display("FAIL anim closed mouth got %b exp 0", bus.mouth_open); end
      if (bus.sprite_dir !== 4'b0000) begin n_fail++; $display("FAIL anim closed dir got %b exp 0000", bus.sprite_dir); end
   endtask

   task automatic test_dir_hold();
      bus.dir_req = 4'b0100;
      repeat (ANIM) step(0, 1, 0, 0);
      bus.dir_req = 4'b0110;
      step(0, 1, 0, 0);
      bus.dir_req = 4'b0000;
      step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      n_chk += 2;
      if (bus.sprite_dir !== 4'b0100) begin n_fail++; $display("FAIL dir_hold sprite_dir got %b exp 0100", bus.sprite_dir); end
      if (bus.sprite_dir !== e_dir)    begin n_fail++; $display("FAIL dir_hold model dir got %b exp %b", bus.sprite_dir, e_dir); end
   endtask

   task automatic test_single_pixel();
      int px, py, t, n_hit, p_hit, pulses, bad;
      clear_bmp(1'b0);
      bmp[4][6] = 1'b1;
      px = $urandom_range(2, 900); py = $urandom_range(0, 900);
      bus.pac_x = CW'(px); bus.pac_y = CW'(py);
      step(0, 1, 0, 0);
      t = 0; n_hit = -1; p_hit = -1; pulses = 0; bad = 0;
      for (int v = py; v < py + SIZE + 2; v++)
         for (int h = px - 2; h < px + SIZE + 2; h++) begin
            step(1, 0, h, v);
            if (h == px + 4 && v == py + 6) n_hit = t;
            if (bus.pac_on === 1'b1) begin pulses++; p_hit = t; end
            n_chk += 3;
            if (bus.pac_on !== e_on)   begin n_fail++; bad++; if (bad < 5) $display("FAIL single_pixel pac_on h=%0d v=%0d got %b exp %b", h, v, bus.pac_on, e_on); end
            if (bus.sprite_x !== e_sx) begin n_fail++; bad++; if (bad < 5) $display("FAIL single_pixel sprite_x h=%0d got %0d exp %0d", h, bus.sprite_x, e_sx); end
            if (bus.sprite_y !== e_sy) begin n_fail++; bad++; if (bad < 5) $display("FAIL single_pixel sprite_y v=%0d got %0d exp %0d", v, bus.sprite_y, e_sy); end
            t++;
         end
      n_chk += 2;
      if (pulses !== 1)         begin n_fail++; $display("FAIL single_pixel pulses got %0d exp 1", pulses); end
      if (p_hit !== n_hit + 1)  begin n_fail++; $display("FAIL single_pixel pulse_tick got %0d exp %0d", p_hit, n_hit + 1); end
   endtask

   task automatic test_high_edge();
      int pulses, bad;
      clear_bmp(1'b1);
      bus.pac_x = 10'd1020; bus.pac_y = 10'd10;
      step(0, 1, 0, 0);
      pulses = 0; bad = 0;
      for (int i = 0; i < 30; i++) begin
         step(1, 0, (1000 + i) % 1024, 12);
         if (bus.pac_on === 1'b1) pulses++;
         n_chk += 2;
         if (bus.pac_on !== e_on)   begin n_fail++; bad++; if (bad < 5) $display("FAIL high_edge pac_on i=%0d got %b exp %b", i, bus.pac_on, e_on); end
         if (bus.sprite_x !== e_sx) begin n_fail++; bad++; if (bad < 5) $display("FAIL high_edge sprite_x i=%0d got %0d exp %0d", i, bus.sprite_x, e_sx); end
      end
      step(1, 0, 500, 500);
      if (bus.pac_on === 1'b1) pulses++;
      n_chk += 1;
      if (pulses !== 4) begin n_fail++; $display("FAIL high_edge pulses got %0d exp 4", pulses); end
   endtask

   task automatic test_random();
      int bad;
      bit pix, fs;
      bad = 0;
      for (int i = 0; i < 32; i++)
         for (int j = 0; j < 32; j++)
            bmp[i][j] = 1'($urandom);
      for (int c = 0; c < 4000; c++) begin
         fs  = ($urandom_range(0, 149) == 0);
         pix = ($urandom_range(0, 3) != 0);
         if (fs) begin
            bus.pac_x   = CW'($urandom_range(0, 1023));
            bus.pac_y   = CW'($urandom_range(0, 1023));
            bus.dir_req = ($urandom_range(0, 1) == 1) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
         end
         step(pix, fs, (m_px + $urandom_range(0, SIZE + 3) - 2 + 1024) % 1024,
                       (m_py + $urandom_range(0, SIZE + 3) - 2 + 1024) % 1024);
         n_chk += 5;
         if (bus.pac_on !== e_on)        begin n_fail++; bad++; if (bad < 5) $display("FAIL random pac_on c=%0d got %b exp %b", c, bus.pac_on, e_on); end
         if (bus.sprite_x !== e_sx)      begin n_fail++; bad++; if (bad < 5) $display("FAIL random sprite_x c=%0d got %0d exp %0d", c, bus.sprite_x, e_sx); end
         if (bus.sprite_y !== e_sy)      begin n_fail++; bad++; if (bad < 5) $display("FAIL random sprite_y c=%0d got %0d exp %0d", c, bus.sprite_y, e_sy); end
         if (bus.sprite_dir !== e_dir)   begin n_fail++; bad++; if (bad < 5) $display("FAIL random sprite_dir c=%0d got %b exp %b", c, bus.sprite_dir, e_dir); end
         if (bus.mouth_open !== m_mouth) begin n_fail++; bad++; if (bad < 5) $display("FAIL random mouth c=%0d got %b exp %b", c, bus.mouth_open, m_mouth); end
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      clear_bmp(1'b1);
      bus.pac_x = 10'd200; bus.pac_y = 10'd200; bus.dir_req = 4'b0001;
      repeat (ANIM) step(0, 1, 0, 0);
      step(1, 0, 205, 205);
      step(1, 0, 206, 205);
      n_chk += 2;
      if (bus.pac_on !== 1'b1)     begin n_fail++; $display("FAIL reset_mid pre pac_on got %b exp 1", bus.pac_on); end
      if (bus.mouth_open !== 1'b1) begin n_fail++; $display("FAIL reset_mid pre mouth got %b exp 1", bus.mouth_open); end
      #2 rst = 1'b1;
      #1;
      n_chk += 3;
      if (bus.pac_on !== 1'b0)        begin n_fail++; $display("FAIL reset_mid pac_on got %b exp 0", bus.pac_on); end
      if (bus.mouth_open !== 1'b0)    begin n_fail++; $display("FAIL reset_mid mouth got %b exp 0", bus.mouth_open); end
      if (bus.sprite_dir !== 4'b0000) begin n_fail++; $display("FAIL reset_mid sprite_dir got %b exp 0000", bus.sprite_dir); end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      step(1, 0, 0, 0);
      n_chk += 1;
      if (bus.pac_on !== 1'b0) begin n_fail++; $display("FAIL reset_mid post pac_on got %b exp 0", bus.pac_on); end
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      model_reset();
      test_reset();
      test_first_frame();
      test_box_edge();
      test_anim();
      test_dir_hold();
      test_single_pixel();
      test_high_edge();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
